// File: rtl/sram_ctrl_if.sv
// Command/response link between the system bus initiator and the SRAM controller.
interface sram_ctrl_if #(parameter int ADDR_W = 19);
  logic              cs_n;
  logic [ADDR_W+16:0] mosi;
  logic [15:0]       miso;
  logic              busy;

  modport master (output cs_n, mosi, input miso, busy);
  modport slave  (input cs_n, mosi, output miso, busy);
endinterface

// File: rtl/sram_ctrl.sv
// Responder for the command link: drives an asynchronous 16-bit SRAM one command
// at a time, optionally stretching each access by WAIT_CYCLES extra cycles.
module sram_ctrl #(
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_W      = 19
) (
  input  logic              sck,
  input  logic              rst,
  sram_ctrl_if.slave        bus,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [15:0]       sram_data,
  output logic              sram_oe_n,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_ub,
  output logic              sram_lb
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  logic [1:0]    state;
  logic          rw_q;
  logic [15:0]   wdata_q;
  logic [15:0]   miso_q;
  logic [CW-1:0] cnt;
  logic          active, done, accept;

  assign active = (state != IDLE);
  // Access finishes on the edge where the wait counter is already exhausted.
  assign done   = active && (cnt == '0);
  assign accept = !bus.cs_n && (!active || done);

  always_ff @(posedge sck) begin
    if (rst) begin
      state     <= IDLE;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      sram_addr <= '0;
      cnt       <= '0;
      miso_q    <= '0;
    end else begin
      if (done && !rw_q)
        miso_q <= sram_data;
      if (accept) begin
        state     <= ACCESS;
        rw_q      <= bus.mosi[ADDR_W+16];
        wdata_q   <= bus.mosi[ADDR_W+15:ADDR_W];
        sram_addr <= bus.mosi[ADDR_W-1:0];
        cnt       <= CW'(WAIT_CYCLES);
      end else if (done) begin
        state <= IDLE;
      end else if (active) begin
        state <= WAIT;
        cnt   <= cnt - 1'b1;
      end
    end
  end

  assign bus.busy  = (cnt != '0);
  assign bus.miso  = miso_q;
  assign sram_ce_n = !active;
  assign sram_ub   = !active;
  assign sram_lb   = !active;
  assign sram_oe_n = !(active && !rw_q);
  assign sram_we_n = !(active && rw_q);
  assign sram_data = (active && rw_q) ? wdata_q : 16'hzzzz;
endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized bench: two controllers (no wait states / two wait states) against SRAM
// models and a transaction-level reference of pins, busy and read data.
module tb_sram_ctrl;
  typedef struct { bit sel; bit rw; logic [15:0] d; logic [18:0] a; } cmd_t;

  logic sck = 1'b0;
  logic rst = 1'b1;
  always #5 sck = ~sck;

  logic [1:0]  cs_a = 2'b11;
  logic [35:0] mosi_a [2];
  wire  [15:0] miso_o [2];
  wire  [18:0] addr_o [2];
  wire  [1:0]  busy_o, ce_o, oe_o, we_o, ub_o, lb_o;
  wire  [15:0] sd0, sd2;

  sram_ctrl_if bus0();
  sram_ctrl_if bus2();
  assign bus0.cs_n = cs_a[0];
  assign bus0.mosi = mosi_a[0];
  assign bus2.cs_n = cs_a[1];
  assign bus2.mosi = mosi_a[1];
  assign miso_o[0] = bus0.miso;
  assign miso_o[1] = bus2.miso;
  assign busy_o[0] = bus0.busy;
  assign busy_o[1] = bus2.busy;

  sram_ctrl #(.WAIT_CYCLES(0)) u0 (
    .sck(sck), .rst(rst), .bus(bus0.slave), .sram_addr(addr_o[0]), .sram_data(sd0),
    .sram_oe_n(oe_o[0]), .sram_ce_n(ce_o[0]), .sram_we_n(we_o[0]),
    .sram_ub(ub_o[0]), .sram_lb(lb_o[0]));
  sram_ctrl #(.WAIT_CYCLES(2)) u2 (
    .sck(sck), .rst(rst), .bus(bus2.slave), .sram_addr(addr_o[1]), .sram_data(sd2),
    .sram_oe_n(oe_o[1]), .sram_ce_n(ce_o[1]), .sram_we_n(we_o[1]),
    .sram_ub(ub_o[1]), .sram_lb(lb_o[1]));

  // External SRAM parts: combinational read, write sampled mid-cycle.
  logic [15:0] mem0 [4096];
  logic [15:0] mem2 [4096];
  assign sd0 = (!ce_o[0] && !oe_o[0] && we_o[0]) ? mem0[addr_o[0][11:0]] : 16'hzzzz;
  assign sd2 = (!ce_o[1] && !oe_o[1] && we_o[1]) ? mem2[addr_o[1][11:0]] : 16'hzzzz;
  always @(negedge sck) if (!ce_o[0] && !we_o[0]) mem0[addr_o[0][11:0]] <= sd0;
  always @(negedge sck) if (!ce_o[1] && !we_o[1]) mem2[addr_o[1][11:0]] <= sd2;

  // Reference state per unit: expected memory, access cycles left, current command.
  logic [15:0] ref_m [2][4096];
  int          rem [2];
  cmd_t        cur [2];
  logic [15:0] exp_miso [2];
  logic [18:0] last_a [2];
  cmd_t        q[$];
  int          ncmp = 0;
  int          nerr = 0;
  int          cu = 0;

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL u%0d %s at %0t: got %h expected %h", cu, tag, $time, got, exp);
    end
  endtask

  task automatic check_unit(input int u);
    bit act;
    logic [15:0] dval;
    cu   = (u == 0) ? 0 : 2;
    act  = (rem[u] != 0);
    dval = (u == 0) ? sd0 : sd2;
    chk("ce_n", 36'(ce_o[u]), 36'(!act));
    chk("ub", 36'(ub_o[u]), 36'(!act));
    chk("lb", 36'(lb_o[u]), 36'(!act));
    chk("oe_n", 36'(oe_o[u]), 36'(!(act && !cur[u].rw)));
    chk("we_n", 36'(we_o[u]), 36'(!(act && cur[u].rw)));
    chk("addr", 36'(addr_o[u]), 36'(last_a[u]));
    chk("busy", 36'(busy_o[u]), 36'(rem[u] > 1));
    chk("miso", 36'(miso_o[u]), 36'(exp_miso[u]));
    if (act && cur[u].rw) chk("wdata", 36'(dval), 36'(cur[u].d));
  endtask

  task automatic push(input bit sel, input bit rw, input logic [15:0] d, input logic [18:0] a);
    cmd_t c;
    c.sel = sel; c.rw = rw; c.d = d; c.a = a;
    q.push_back(c);
  endtask

  // Drain the command queue into unit u; w is its wait-state count.
  task automatic run(input int u, input int w);
    cmd_t c;
    int guard = 0;
    while ((q.size() != 0 || rem[u] != 0) && guard < 5000) begin
      guard++;
      c.sel = 1'b0; c.rw = 1'b0; c.d = '0; c.a = '0;
      if (rem[u] > 1) begin
        cs_a[u]   = 1'($urandom_range(0, 1));
        mosi_a[u] = 36'({$urandom(), $urandom()});
      end else begin
        if (q.size() != 0) c = q.pop_front();
        cs_a[u]   = !c.sel;
        mosi_a[u] = {c.rw, c.d, c.a};
      end
      @(posedge sck); #1;
      if (rem[u] > 0) begin
        rem[u]--;
        if (rem[u] == 0 && !cur[u].rw) exp_miso[u] = ref_m[u][cur[u].a[11:0]];
      end
      if (rem[u] == 0 && c.sel) begin
        cur[u]    = c;
        rem[u]    = w + 1;
        last_a[u] = c.a;
        if (c.rw) ref_m[u][c.a[11:0]] = c.d;
      end
      check_unit(u);
    end
    if (guard >= 5000) chk("timeout", 36'd1, 36'd0);
    cs_a[u] = 1'b1;
  endtask

  task automatic do_reset;
    cs_a = 2'b11;
    rst  = 1'b1;
    repeat (2) @(posedge sck);
    #1;
    for (int u = 0; u < 2; u++) begin
      rem[u] = 0; exp_miso[u] = '0; last_a[u] = '0;
      check_unit(u);
    end
    rst = 1'b0;
  endtask

  task automatic rand_phase(input int u, input int w);
    for (int i = 0; i < 16; i++) push(1'b1, 1'b1, 16'($urandom), 19'(12'h040 + i));
    for (int i = 0; i < 80; i++)
      push(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 16'($urandom),
           19'(12'h040 + $urandom_range(0, 15)));
    run(u, w);
  endtask

  task automatic directed(input int u, input int w);
    push(1, 1, 16'hBEEF, 19'h00123);
    push(1, 0, 16'h0000, 19'h00123);
    push(1, 1, 16'h1111, 19'h00010);
    push(1, 1, 16'h2222, 19'h00011);
    push(1, 0, 16'h0000, 19'h00010);
    push(1, 0, 16'h0000, 19'h00011);
    push(0, 0, 16'h0000, 19'h00000);
    push(0, 0, 16'h0000, 19'h00000);
    push(0, 0, 16'h0000, 19'h00000);
    push(1, 1, 16'h0F0F, 19'h00300);
    push(1, 1, 16'hA5A5, 19'h00200);
    push(0, 0, 16'h0000, 19'h00000);
    push(1, 0, 16'h0000, 19'h00200);
    push(1, 1, 16'h5555, 19'h00301);
    push(1, 0, 16'h0000, 19'h00300);
    push(0, 0, 16'h0000, 19'h00000);
    run(u, w);
  endtask

  initial begin
    mosi_a[0] = '0;
    mosi_a[1] = '0;
    do_reset();
    directed(0, 0);
    directed(1, 2);
    rand_phase(0, 0);
    rand_phase(1, 2);
    // Reset in the middle of a write on both units.
    cs_a = 2'b00;
    mosi_a[0] = {1'b1, 16'h7E7E, 19'h00041};
    mosi_a[1] = {1'b1, 16'h8181, 19'h00042};
    @(posedge sck); #1;
    cu = 0; chk("rst_pre_we_n", 36'(we_o[0]), 36'd0);
    cu = 2; chk("rst_pre_we_n", 36'(we_o[1]), 36'd0);
    chk("rst_pre_busy", 36'(busy_o[1]), 36'd1);
    ref_m[0][12'h041] = 16'h7E7E;
    ref_m[1][12'h042] = 16'h8181;
    do_reset();
    push(1, 0, 16'h0000, 19'h00041);
    run(0, 0);
    push(1, 0, 16'h0000, 19'h00042);
    run(1, 2);
    rand_phase(0, 0);
    rand_phase(1, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
